// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store funct3 encodings, timeout default and request legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 16;

  // Illegal encoding or misaligned halfword/word access; bytes are always aligned.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic illegal;
    logic misaligned;
    illegal    = we ? (f3 > F3_SW)
                    : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misaligned = (f3[1:0] == 2'b01 && off[0]) ||
                 (f3[1:0] == 2'b10 && off != 2'b00);
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store data replication and
// load data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] lane;

  always_comb begin
    lane      = rdata >> {addr_lo, 3'b000};
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = '0;

    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase

    case (funct3)
      F3_LB:   rdata_ext = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   rdata_ext = {{16{lane[15]}}, lane[15:0]};
      F3_LW:   rdata_ext = rdata;
      F3_LBU:  rdata_ext = {24'h0, lane[7:0]};
      F3_LHU:  rdata_ext = {16'h0, lane[15:0]};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core request at a time, runs a single
// request/grant/completion bus transaction and returns a one-cycle response.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  lsu_state_e  state;
  logic [CW-1:0] cnt;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;

  logic [2:0]  a_funct3;
  logic [1:0]  a_off;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;

  // In IDLE the lane logic sees the live request so the bus outputs can be
  // registered on the accepting edge; afterwards it sees the latched copy.
  always_comb begin
    a_funct3 = lat_funct3;
    a_off    = lat_off;
    if (state == S_IDLE) begin
      a_funct3 = req_funct3;
      a_off    = req_addr[1:0];
    end
  end

  lsu_align u_align (
    .funct3    (a_funct3),
    .addr_lo   (a_off),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  assign req_ready = (state == S_IDLE);
  assign stall     = req_valid & ~rsp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_funct3 <= '0;
      lat_off    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_funct3 <= req_funct3;
            lat_off    <= req_addr[1:0];
            mem_we     <= req_we;
            if (access_err(req_we, req_funct3, req_addr[1:0])) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= S_REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= wdata_rep;
            end
          end
        end
        S_REQ, S_WAIT: begin
          // Completion on the last allowed cycle wins over the timeout.
          if (state == S_WAIT && mem_rvalid) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= mem_we ? '0 : rdata_ext;
          end else if (cnt == CNT_LAST) begin
            state     <= S_RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == S_REQ && mem_gnt) begin
              mem_req <= 1'b0;
              state   <= S_WAIT;
            end
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized transactions
// checked against a behavioural access model.
module tb_lsu;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observations collected by run_txn
  int          o_lat;
  logic        o_err, o_req_seen, o_unstable, o_stall_bad, o_hung, o_single, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    logic [1:0] s;
    s = f3[1:0];
    return 1 << s;
  endfunction

  function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic ill;
    ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    return ill || ((addr % acc_size(f3)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = acc_size(f3);
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    sz = acc_size(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * (addr % 4));
    case (f3)
      3'd0:    return (v & 32'h80)   ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
      3'd1:    return (v & 32'h8000) ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
      3'd2:    return d;
      3'd4:    return v & 32'hFF;
      3'd5:    return v & 32'hFFFF;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- transaction driver / monitor ----------------
  // g: extra REQ cycles before grant; w: extra WAIT cycles before completion.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int g, input int w);
    int   k = 0;
    int   wc = 0;
    int   cyc = 0;
    logic granted = 1'b0;
    logic done = 1'b0;
    o_req_seen = 1'b0; o_unstable = 1'b0; o_stall_bad = 1'b0; o_hung = 1'b0;
    o_single = 1'b0; o_lat = -1; o_err = 1'bx; o_rdata = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_rdata = rdata; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid === 1'b1) begin
        done = 1'b1; o_lat = cyc; o_err = rsp_err; o_rdata = rsp_rdata;
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end else begin
        if (stall !== 1'b1 || req_ready !== 1'b0) o_stall_bad = 1'b1;
        if (mem_req === 1'b1) begin
          if (!o_req_seen) begin
            o_req_seen = 1'b1; o_addr = mem_addr; o_be = mem_be;
            o_wdata = mem_wdata; o_we = mem_we;
          end else if (mem_addr !== o_addr || mem_be !== o_be ||
                       mem_wdata !== o_wdata || mem_we !== o_we) begin
            o_unstable = 1'b1;
          end
          k++;
          mem_gnt = (k > g);
          if (mem_gnt) granted = 1'b1;
          mem_rvalid = 1'($urandom_range(0, 1));
        end else begin
          mem_gnt = 1'b0;
          mem_rvalid = 1'b0;
          if (granted) begin
            wc++;
            mem_rvalid = (wc > w);
          end
        end
      end
    end
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!done) o_hung = 1'b1;
    else begin
      @(negedge clk);
      o_single = (rsp_valid === 1'b0 && req_ready === 1'b1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp: got err %b rdata %h want 0/0", rsp_err, rsp_rdata); end
    n_cmp++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got req %b we %b want 0/0", mem_req, mem_we); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_bus: got %h %h %h want 0", mem_addr, mem_be, mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    n_cmp++; if (o_addr !== 32'h100 || o_be !== 4'b1111) begin n_bad++; $display("FAIL sw_bus: got addr %h be %b want 00000100 1111", o_addr, o_be); end
    n_cmp++; if (o_wdata !== 32'hDEADBEEF || o_we !== 1'b1) begin n_bad++; $display("FAIL sw_wdata: got %h we %b want deadbeef 1", o_wdata, o_we); end
    n_cmp++; if (o_lat !== 3 || o_err !== 1'b0) begin n_bad++; $display("FAIL sw_rsp: got lat %0d err %b want 3 0", o_lat, o_err); end
  endtask

  task automatic test_load_byte();
    run_txn(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_FFFF, 0, 0);
    n_cmp++; if (o_be !== 4'b1000 || o_addr !== 32'h200) begin n_bad++; $display("FAIL lb_bus: got be %b addr %h want 1000 00000200", o_be, o_addr); end
    n_cmp++; if (o_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffff80", o_rdata); end
    run_txn(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_FFFF, 0, 0);
    n_cmp++; if (o_rdata !== 32'h0000_0080 || o_err !== 1'b0) begin n_bad++; $display("FAIL lbu_rdata: got %h err %b want 00000080 0", o_rdata, o_err); end
  endtask

  task automatic test_store_half();
    run_txn(1'b1, 3'b001, 32'h102, 32'h1234, 32'h0, 0, 0);
    n_cmp++; if (o_be !== 4'b1100) begin n_bad++; $display("FAIL sh_be: got %b want 1100", o_be); end
    n_cmp++; if (o_wdata !== 32'h1234_1234) begin n_bad++; $display("FAIL sh_wdata: got %h want 12341234", o_wdata); end
  endtask

  task automatic test_errors();
    run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
    n_cmp++; if (o_req_seen !== 1'b0 || o_lat !== 1 || o_err !== 1'b1) begin n_bad++; $display("FAIL lw_misaligned: got req %b lat %0d err %b want 0 1 1", o_req_seen, o_lat, o_err); end
    run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
    n_cmp++; if (o_req_seen !== 1'b0 || o_lat !== 1 || o_err !== 1'b1) begin n_bad++; $display("FAIL ld_illegal: got req %b lat %0d err %b want 0 1 1", o_req_seen, o_lat, o_err); end
    n_cmp++; if (o_rdata !== 32'h0) begin n_bad++; $display("FAIL err_rdata: got %h want 0", o_rdata); end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h5555_AAAA, 1000, 0);
    n_cmp++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin n_bad++; $display("FAIL timeout_rsp: got err %b rdata %h want 1 0", o_err, o_rdata); end
    n_cmp++; if (o_lat !== TO + 1) begin n_bad++; $display("FAIL timeout_lat: got %0d want %0d", o_lat, TO + 1); end
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL late_rvalid: got rsp %b ready %b want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || req_ready !== 1'b0) begin n_bad++; $display("FAIL wait_state: got req %b ready %b want 0 0", mem_req, req_ready); end
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || mem_req !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid: got ready %b req %b rsp %b want 1 0 0", req_ready, mem_req, rsp_valid); end
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_late_rvalid: got rsp %b want 0", rsp_valid); end
    run_txn(1'b0, 3'b001, 32'h302, 32'h0, 32'hBEEF_0000, 0, 1);
    n_cmp++; if (o_rdata !== 32'hFFFF_BEEF || o_lat !== 4 || o_err !== 1'b0) begin n_bad++; $display("FAIL post_rst_txn: got %h lat %0d err %b want ffffbeef 4 0", o_rdata, o_lat, o_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      logic        we, e_err, e_to;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rd, e_rdata;
      int          g, w, e_lat;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom; wd = $urandom; rd = $urandom;
      g = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 2));
      w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 2));
      e_err = m_err(we, f3, addr);
      e_to  = !e_err && (g + w + 2 > TO);
      e_lat = e_err ? 1 : (e_to ? TO + 1 : 3 + g + w);
      e_rdata = (e_err || e_to || we) ? 32'h0 : m_rdata(f3, addr, rd);
      run_txn(we, f3, addr, wd, rd, g, w);
      n_cmp++; if (o_hung) begin n_bad++; $display("FAIL rnd_hang[%0d]: got no response want lat %0d", i, e_lat); end
      n_cmp++; if (o_err !== (e_err | e_to) || o_lat !== e_lat) begin n_bad++; $display("FAIL rnd_rsp[%0d]: got err %b lat %0d want %b %0d", i, o_err, o_lat, e_err | e_to, e_lat); end
      n_cmp++; if (o_rdata !== e_rdata) begin n_bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, o_rdata, e_rdata); end
      n_cmp++; if (o_req_seen !== !e_err) begin n_bad++; $display("FAIL rnd_memreq[%0d]: got %b want %b", i, o_req_seen, !e_err); end
      n_cmp++; if (o_stall_bad || o_unstable || !o_single) begin n_bad++; $display("FAIL rnd_protocol[%0d]: got stall_bad %b unstable %b single %b want 0 0 1", i, o_stall_bad, o_unstable, o_single); end
      if (o_req_seen && !e_err) begin
        n_cmp++; if (o_addr !== (addr & 32'hFFFF_FFFC) || o_be !== m_be(f3, addr) || o_we !== we) begin n_bad++; $display("FAIL rnd_bus[%0d]: got %h %b %b want %h %b %b", i, o_addr, o_be, o_we, addr & 32'hFFFF_FFFC, m_be(f3, addr), we); end
        if (we) begin
          n_cmp++; if (o_wdata !== m_wdata(f3, wd)) begin n_bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, o_wdata, m_wdata(f3, wd)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: bus cycles allowed from first mem_req assertion to mem_rvalid before an error response.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; one clock, and reset is synchronous and active-high.
REQ-004 req_valid  input  1  core load/store request, held stable by the core until rsp_valid.
REQ-005 req_we  input  1  1 = store (core dm_en), 0 = load.
REQ-006 req_funct3  input  3  access size/sign (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
REQ-007 req_addr  input  32  byte address from ALU.
REQ-008 req_wdata  input  32  store data (rs2).
REQ-009 req_ready  output  1  LSU can accept a request.
REQ-010 rsp_valid  output  1  one-cycle response strobe.
REQ-011 rsp_rdata  output  32  aligned, extended load data (0 for stores and errors).
REQ-012 rsp_err  output  1  misaligned, illegal funct3 or timeout; qualified by rsp_valid.
REQ-013 stall  output  1  pipeline hold.
REQ-014 mem_req, mem_we  output  1 each  memory request and write flag.
REQ-015 mem_addr  output  32  word address (bits [1:0] = 0).
REQ-016 mem_be  output  4  byte enables; mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_gnt, mem_rvalid  input  1 each  grant; completion (loads and stores); mem_rdata  input  32.

Function
REQ-018 FSM states IDLE, REQ, WAIT, RESP; req_ready = (state == IDLE).
REQ-019 IDLE: on req_valid, latch we/funct3/addr/wdata; go to RESP with error if illegal or misaligned, otherwise go to REQ.
REQ-020 Illegal: loads funct3 in {011,110,111}; stores funct3 > 010.
REQ-021 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0; byte accesses are never misaligned.
REQ-022 Errored requests SHALL never assert mem_req.
REQ-023 REQ: mem_req=1 with address/be/wdata/we stable until mem_gnt; on mem_gnt go to WAIT.
REQ-024 WAIT: mem_req=0; mem_rvalid moves to RESP, and mem_rdata is latched and extended for loads. mem_rvalid outside WAIT is ignored.
REQ-025 Timeout counter clears on entry to REQ and increments each cycle in REQ/WAIT; at TIMEOUT_CYC go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-026 RESP: rsp_valid=1 for exactly one cycle, then IDLE; no new acceptance in RESP.
REQ-027 stall = req_valid & ~rsp_valid.
REQ-028 Minimum latency: accept at cycle 0, mem_gnt at cycle 1, mem_rvalid at cycle 2, rsp_valid at cycle 3.
REQ-029 mem_be: SB 0001<<addr[1:0]; SH 0011<<{addr[1],1'b0}; SW 1111.
REQ-030 mem_wdata: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-031 Load extraction uses the latched addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.

Reset
REQ-032 rst forces IDLE, clears the counter and latches, and zeroes rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_be and mem_wdata; req_ready=1 from the first cycle after reset.
REQ-033 Reset mid-transaction abandons it with no response; a late mem_rvalid is then ignored.

Structure
REQ-034 Package lsu_pkg holds: the state enum, funct3 constants (LB..LHU, SB..SW) and the TIMEOUT_CYC default.
REQ-035 Byte-enable generation, write replication and load extraction/extension live in one combinational sub-module, lsu_align.

Verification
REQ-036 SW addr 0x100, data 0xDEADBEEF, gnt at cycle 1, rvalid at cycle 2 -> mem_addr 0x100, mem_be 1111; rsp_valid at cycle 3, rsp_err 0.
REQ-037 LB addr 0x203, mem_rdata 0x80FF_FF_FF -> mem_be 1000, rsp_rdata 0xFFFFFF80; repeated with LBU -> 0x00000080.
REQ-038 SH addr 0x102, data 0x1234 -> mem_be 1100, mem_wdata 0x12341234.
REQ-039 LW addr 0x101 -> no mem_req, rsp_valid at cycle 1, rsp_err 1; load funct3 011 -> same behaviour.
REQ-040 mem_gnt withheld for TIMEOUT_CYC=16 cycles -> rsp_err 1, rsp_rdata 0; a later mem_rvalid is ignored.
REQ-041 rst asserted while in WAIT -> IDLE next cycle, mem_req 0, no rsp_valid, next request served normally.
